// File: rtl/div.sv
// Multi-cycle restoring divider for DIV/DIVU: 32 shift-subtract steps on a
// 65-bit working register, with start/annul handshake to the EX stage.
module div (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        signed_div_i,
  input  logic [31:0] div_opdata1_i,
  input  logic [31:0] div_opdata2_i,
  input  logic        div_start_i,
  input  logic        annul_i,
  output logic [63:0] div_result_o,
  output logic        div_ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic [64:0] work, work_n;
  logic [31:0] divisor, divisor_n;
  logic        neg1, neg1_n, neg2, neg2_n;
  logic [63:0] result_n;
  logic        ready_n;

  logic [32:0] sub;
  logic [31:0] mag1, mag2, q_mag, r_mag, q_fix, r_fix;
  logic        op1_neg, op2_neg;

  always_comb begin
    // Trial subtraction of the divisor from the current partial remainder
    sub     = {1'b0, work[63:32]} - {1'b0, divisor};
    op1_neg = signed_div_i & div_opdata1_i[31];
    op2_neg = signed_div_i & div_opdata2_i[31];
    mag1    = op1_neg ? (~div_opdata1_i + 32'd1) : div_opdata1_i;
    mag2    = op2_neg ? (~div_opdata2_i + 32'd1) : div_opdata2_i;
    q_mag   = work[31:0];
    r_mag   = work[64:33];
    q_fix   = (neg1 ^ neg2) ? (~q_mag + 32'd1) : q_mag;
    r_fix   = neg1 ? (~r_mag + 32'd1) : r_mag;

    state_n   = state;
    cnt_n     = cnt;
    work_n    = work;
    divisor_n = divisor;
    neg1_n    = neg1;
    neg2_n    = neg2;
    result_n  = div_result_o;
    ready_n   = div_ready_o;

    case (state)
      FREE: begin
        result_n = '0;
        ready_n  = 1'b0;
        if (div_start_i && !annul_i) begin
          neg1_n    = op1_neg;
          neg2_n    = op2_neg;
          divisor_n = mag2;
          work_n    = {32'd0, mag1, 1'b0};
          cnt_n     = 6'd0;
          state_n   = (div_opdata2_i == 32'd0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        result_n = '0;
        ready_n  = 1'b0;
        state_n  = (annul_i || !div_start_i) ? FREE : END;
      end
      ON: begin
        if (annul_i || !div_start_i) begin
          state_n  = FREE;
          result_n = '0;
          ready_n  = 1'b0;
        end else if (cnt != 6'd32) begin
          work_n = sub[32] ? {work[63:0], 1'b0} : {sub[31:0], work[31:0], 1'b1};
          cnt_n  = cnt + 6'd1;
        end else begin
          result_n = {r_fix, q_fix};
          ready_n  = 1'b1;
          state_n  = END;
        end
      end
      END: begin
        if (annul_i || !div_start_i) begin
          state_n  = FREE;
          result_n = '0;
          ready_n  = 1'b0;
        end else begin
          ready_n = 1'b1;
        end
      end
      default: begin
        state_n  = FREE;
        result_n = '0;
        ready_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state        <= FREE;
      cnt          <= '0;
      work         <= '0;
      divisor      <= '0;
      neg1         <= 1'b0;
      neg2         <= 1'b0;
      div_result_o <= '0;
      div_ready_o  <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      work         <= work_n;
      divisor      <= divisor_n;
      neg1         <= neg1_n;
      neg2         <= neg2_n;
      div_result_o <= result_n;
      div_ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed bench for div: latency, signed/unsigned results, divide-by-zero,
// annul and mid-operation reset.
module tb_div;
  logic        clk = 1'b0;
  logic        rst, sgn, start, annul;
  logic [31:0] a, b;
  logic [63:0] res, r;
  logic        rdy;
  int          lat;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  div dut (
    .cpu_clk_50M  (clk),
    .cpu_rst      (rst),
    .signed_div_i (sgn),
    .div_opdata1_i(a),
    .div_opdata2_i(b),
    .div_start_i  (start),
    .annul_i      (annul),
    .div_result_o (res),
    .div_ready_o  (rdy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Starts a divide and waits for ready; operands are scrambled right after
  // the start edge so any late re-sampling shows up in the result.
  task automatic run(input logic s, input logic [31:0] x, input logic [31:0] y,
                     output logic [63:0] rr, output int l);
    @(negedge clk);
    rst = 1'b0; sgn = s; a = x; b = y; start = 1'b1; annul = 1'b0;
    l = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin a = $urandom; b = $urandom; sgn = ~s; end
      if (rdy) begin l = n; break; end
    end
    rr = res;
  endtask

  task automatic release_chk(input string tag);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_free_rdy"}, {63'd0, rdy}, 64'd0);
    chk({tag, "_free_res"}, res, 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; annul = 1'b0; sgn = 1'b0; a = 32'd7; b = 32'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", {63'd0, rdy}, 64'd0);
    chk("reset_res", res, 64'd0);
    start = 1'b0;

    run(1'b0, 32'd7, 32'd2, r, lat);
    chk("u7_2_lat", 64'(lat), 64'd33);
    chk("u7_2_res", r, 64'h00000001_00000003);
    repeat (2) begin
      @(posedge clk); #1;
      chk("u7_2_hold_rdy", {63'd0, rdy}, 64'd1);
      chk("u7_2_hold_res", res, 64'h00000001_00000003);
    end
    release_chk("u7_2");

    run(1'b1, 32'hFFFFFFF9, 32'd2, r, lat);
    chk("sm7_2_res", r, 64'hFFFFFFFF_FFFFFFFD);
    release_chk("sm7_2");

    run(1'b1, 32'h80000000, 32'hFFFFFFFF, r, lat);
    chk("s_min_m1_res", r, 64'h00000000_80000000);
    release_chk("s_min_m1");

    run(1'b0, 32'hFFFFFFFF, 32'h00000010, r, lat);
    chk("u_max_16_res", r, 64'h0000000F_0FFFFFFF);
    release_chk("u_max_16");

    run(1'b1, 32'd7, 32'hFFFFFFFE, r, lat);
    chk("s7_m2_res", r, 64'h00000001_FFFFFFFD);
    release_chk("s7_m2");

    run(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, r, lat);
    chk("sm7_m2_res", r, 64'hFFFFFFFF_00000003);
    release_chk("sm7_m2");

    run(1'b0, 32'd5, 32'd0, r, lat);
    chk("byzero_lat", 64'(lat), 64'd2);
    chk("byzero_res", r, 64'd0);
    release_chk("byzero");

    // Annul at iteration 10, then an immediate fresh divide
    @(negedge clk); sgn = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;
    chk("annul_rdy", {63'd0, rdy}, 64'd0);
    chk("annul_res", res, 64'd0);
    run(1'b0, 32'd100, 32'd7, r, lat);
    chk("after_annul_lat", 64'(lat), 64'd33);
    chk("after_annul_res", r, 64'h00000002_0000000E);
    release_chk("after_annul");

    // Annul beats a held start in END
    run(1'b0, 32'd9, 32'd0, r, lat);
    chk("end_annul_pre_rdy", {63'd0, rdy}, 64'd1);
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;
    chk("end_annul_rdy", {63'd0, rdy}, 64'd0);
    @(negedge clk); annul = 1'b0; start = 1'b0;
    @(posedge clk);

    // Reset at iteration 20, start kept high, then a fresh divide
    @(negedge clk); sgn = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_rst_rdy", {63'd0, rdy}, 64'd0);
      chk("mid_rst_res", res, 64'd0);
    end
    run(1'b0, 32'd1000, 32'd3, r, lat);
    chk("after_rst_lat", 64'(lat), 64'd33);
    chk("after_rst_res", r, 64'h00000001_0000014D);
    release_chk("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The module SHALL have the port `cpu_clk_50M`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port `cpu_rst`: input, 1 bit, reset, synchronous and active-high.
REQ-003 The module SHALL have the port `signed_div_i`: input, 1 bit; 1 selects a signed (DIV) divide and 0 selects an unsigned (DIVU) divide; sampled at start.
REQ-004 The module SHALL have the port `div_opdata1_i`: input, 32 bits, the dividend; sampled at start.
REQ-005 The module SHALL have the port `div_opdata2_i`: input, 32 bits, the divisor; sampled at start.
REQ-006 The module SHALL have the port `div_start_i`: input, 1 bit; the EX stage holds it at 1 while it wants a divide and the result is not ready.
REQ-007 The module SHALL have the port `annul_i`: input, 1 bit, a pipeline flush that aborts any divide in progress.
REQ-008 The module SHALL have the port `div_result_o`: output, 64 bits, registered; bits [63:32] are the remainder (to HI) and bits [31:0] are the quotient (to LO).
REQ-009 The module SHALL have the port `div_ready_o`: output, 1 bit, registered; 1 means `div_result_o` is valid.

Function
REQ-010 The module SHALL implement a four-state FSM with states FREE, BYZERO, ON and END.
REQ-011 In FREE, with `div_start_i`=1 and `annul_i`=0, the module SHALL, at the next edge:
- latch both operands;
- go to BYZERO if the divisor is 0, otherwise go to ON with the iteration counter cleared.
REQ-012 In FREE, the module SHALL hold `div_ready_o`=0 and `div_result_o`=0.
REQ-013 BYZERO SHALL go to END at the next edge, with `div_result_o`=0 and `div_ready_o`=1.
REQ-014 Iteration in ON SHALL follow these rules:
- exactly one restoring shift-subtract step per cycle on a 65-bit working register;
- a 6-bit counter runs 0 to 31;
- 32 iterations in total.
REQ-015 For signed divides, the module SHALL take the two's-complement magnitude of each negative operand when it latches them.
REQ-016 On the edge where the counter reaches 32, the module SHALL do all of the following:
- negate the quotient if `signed_div_i` was 1 and the operand signs differ;
- give the remainder the sign of the dividend for signed divides;
- register the result, set `div_ready_o`=1 and go to END.
REQ-017 Latency: if start is sampled at edge k, `div_ready_o` SHALL first be high after edge k+33 (divisor nonzero) or after edge k+2 (divisor zero).
REQ-018 In END, while `div_start_i`=1, the module SHALL hold the result and keep `div_ready_o`=1.
REQ-019 When `div_start_i`=0 in END, the module SHALL go to FREE at the next edge, clearing `div_ready_o` and `div_result_o`.
REQ-020 If `annul_i`=1 or `div_start_i`=0 in ON or BYZERO, the module SHALL go to FREE at the next edge with outputs cleared; no partial result is ever presented.
REQ-021 `annul_i` SHALL take priority over `div_start_i` in every state.
REQ-022 Operand changes after start is sampled SHALL be ignored until the FSM returns to FREE.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (wrap, no exception).
REQ-024 A new divide SHALL start no earlier than one cycle after END returns to FREE, i.e. at minimum one FREE cycle between divides.
REQ-025 `div_ready_o` SHALL be driven only from a flop, never combinationally from the inputs.

Reset
REQ-026 When `cpu_rst`=1 is sampled at an edge, the module SHALL set state to FREE, clear `div_ready_o`, `div_result_o`, the counter and the working registers, and latch no operands.
REQ-027 A reset in any state, including mid-ON, SHALL abort the operation with no later ready pulse.
REQ-028 Reset SHALL take priority over `annul_i` and `div_start_i`.

Verification
REQ-029 Unsigned 7/2 (`div_start_i` held): `div_ready_o` SHALL rise 33 cycles after the start edge with `div_result_o`=0x00000001_00000003.
REQ-030 Signed -7/2 (0xFFFFFFF9 / 0x00000002): `div_result_o` SHALL be 0xFFFFFFFF_FFFFFFFD.
REQ-031 Signed 0x80000000 / 0xFFFFFFFF: `div_result_o` SHALL be 0x00000000_80000000; unsigned 0xFFFFFFFF / 0x00000010 SHALL give 0x0000000F_0FFFFFFF.
REQ-032 Divisor 0: `div_ready_o` SHALL be high two cycles after start with result 0; after dropping `div_start_i` the module SHALL be in FREE with result 0 one cycle later.
REQ-033 `annul_i` pulsed at iteration 10: the module SHALL be in FREE with `div_ready_o`=0 next cycle and no ready pulse afterwards; an immediate new 100/7 divide SHALL give 0x00000002_0000000E.
REQ-034 `cpu_rst` asserted at iteration 20, then released with start held: a fresh divide SHALL complete with correct result and full 33-cycle latency.
